// File: rtl/strram_arbiter.sv
// rtl/strram_arbiter.sv - two-requester round-robin arbiter driving a string-RAM peripheral bus
// Each granted access is serialised into register writes/reads on the peripheral
// bus: writes go data -> address -> write strobe; reads go address -> read strobe
// -> read-data register -> capture. Every bus phase is held HOLD cycles.
module strram_arbiter #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       busy,
  output logic       per_cs,
  output logic       per_wr,
  output logic       per_rd,
  output logic [3:0] per_addr,
  output logic [7:0] per_dat_in,
  input  logic [7:0] per_dat_out
);

  typedef enum logic [3:0] {
    IDLE, W_DATA, W_ADDR, W_STB, R_ADDR, R_STB, R_DAT, R_CAP, DONE
  } state_t;

  localparam logic [3:0] REG_WDATA = 4'h0;
  localparam logic [3:0] REG_ADDR  = 4'h4;
  localparam logic [3:0] REG_CMD   = 4'h8;
  localparam logic [3:0] REG_RDATA = 4'h2;
  localparam logic [3:0] LAST_CNT  = 4'(HOLD - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       last_id;
  logic       gid;
  logic       g_we;
  logic [7:0] g_addr;
  logic [7:0] g_wdata;
  logic       grant;
  logic       grant_id;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       phase_end;

  // Round-robin pick: a tie goes to whoever was not granted last
  always_comb begin
    grant     = m0_req | m1_req;
    grant_id  = (m0_req && m1_req) ? ~last_id : m1_req;
    sel_we    = grant_id ? m1_we    : m0_we;
    sel_addr  = grant_id ? m1_addr  : m0_addr;
    sel_wdata = grant_id ? m1_wdata : m0_wdata;
    phase_end = (cnt == LAST_CNT);
  end

  // State and phase counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Latch the winner's request fields and advance the round-robin pointer on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
      gid     <= 1'b0;
      g_we    <= 1'b0;
      g_addr  <= '0;
      g_wdata <= '0;
    end else if (state == IDLE && grant) begin
      last_id <= grant_id;
      gid     <= grant_id;
      g_we    <= sel_we;
      g_addr  <= sel_addr;
      g_wdata <= sel_wdata;
    end
  end

  // Capture peripheral read data into the granted requester's rdata when leaving R_CAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == R_CAP) begin
      if (gid) m1_rdata <= per_dat_out;
      else     m0_rdata <= per_dat_out;
    end
  end

  // Next state, phase counting and bus outputs decoded from registered state
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    per_cs     = 1'b0;
    per_wr     = 1'b0;
    per_rd     = 1'b0;
    per_addr   = 4'h0;
    per_dat_in = 8'h00;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (grant) state_nx = sel_we ? W_DATA : R_ADDR;
      end
      W_DATA: begin
        per_cs     = 1'b1;
        per_wr     = 1'b1;
        per_addr   = REG_WDATA;
        per_dat_in = g_wdata;
        if (phase_end) begin
          state_nx = W_ADDR;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      W_ADDR: begin
        per_cs     = 1'b1;
        per_wr     = 1'b1;
        per_addr   = REG_ADDR;
        per_dat_in = g_addr;
        if (phase_end) begin
          state_nx = W_STB;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      W_STB: begin
        per_cs   = 1'b1;
        per_wr   = 1'b1;
        per_addr = REG_CMD;
        if (phase_end) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      R_ADDR: begin
        per_cs     = 1'b1;
        per_wr     = 1'b1;
        per_addr   = REG_ADDR;
        per_dat_in = g_addr;
        if (phase_end) begin
          state_nx = R_STB;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      R_STB: begin
        per_cs   = 1'b1;
        per_rd   = 1'b1;
        per_addr = REG_CMD;
        if (phase_end) begin
          state_nx = R_DAT;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      R_DAT: begin
        per_cs   = 1'b1;
        per_rd   = 1'b1;
        per_addr = REG_RDATA;
        if (phase_end) begin
          state_nx = R_CAP;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      R_CAP: begin
        state_nx = DONE;
        cnt_nx   = '0;
      end
      DONE: begin
        m0_ack   = ~gid;
        m1_ack   = gid;
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_strram_arbiter.sv
// tb/tb_strram_arbiter.sv - scoreboard bench for strram_arbiter
module tb_strram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic       m0_ack, m1_ack, busy, per_cs, per_wr, per_rd;
  logic [7:0] m0_rdata, m1_rdata, per_dat_in;
  logic [7:0] per_dat_out = 0;
  logic [3:0] per_addr;

  logic       h0_req = 0, h0_we = 0, h1_req = 0, h1_we = 0;
  logic [7:0] h0_addr = 0, h0_wdata = 0, h1_addr = 0, h1_wdata = 0;
  logic       h0_ack, h1_ack, h_busy, h_cs, h_wr, h_rd;
  logic [7:0] h0_rdata, h1_rdata, h_dat_in;
  logic [7:0] h_dat_out = 0;
  logic [3:0] h_addr;

  int total = 0;
  int bad = 0;

  typedef struct {logic [3:0] addr; logic wr; logic rd; logic [7:0] dat;} bus_t;
  typedef struct {logic id; logic [7:0] rdata; int cyc;} ack_t;
  bus_t bus_q[$];
  ack_t ack_q[$];
  bit   mon_en = 1'b0;
  bit   busy_prev = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  strram_arbiter #(.HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .busy(busy), .per_cs(per_cs), .per_wr(per_wr), .per_rd(per_rd),
    .per_addr(per_addr), .per_dat_in(per_dat_in), .per_dat_out(per_dat_out)
  );

  strram_arbiter #(.HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(h0_req), .m0_we(h0_we), .m0_addr(h0_addr), .m0_wdata(h0_wdata),
    .m0_ack(h0_ack), .m0_rdata(h0_rdata),
    .m1_req(h1_req), .m1_we(h1_we), .m1_addr(h1_addr), .m1_wdata(h1_wdata),
    .m1_ack(h1_ack), .m1_rdata(h1_rdata),
    .busy(h_busy), .per_cs(h_cs), .per_wr(h_wr), .per_rd(h_rd),
    .per_addr(h_addr), .per_dat_in(h_dat_in), .per_dat_out(h_dat_out)
  );

  // Monitor: pops expected bus phases and acks as the HOLD=1 DUT produces them
  always @(negedge clk) begin
    bus_t eb;
    ack_t ea;
    logic [7:0] got_rd;
    if (!rst_n || !mon_en) begin
      busy_prev = 1'b0;
      cyc = 0;
    end else begin
      if (busy && !busy_prev) cyc = 1;
      else if (busy) cyc = cyc + 1;
      busy_prev = busy;
      if (per_cs) begin
        total++;
        if (bus_q.size() == 0) begin
          bad++;
          $display("FAIL bus_unexpected: got addr=%h wr=%b rd=%b, expected no bus phase", per_addr, per_wr, per_rd);
        end else begin
          eb = bus_q.pop_front();
          if (per_addr !== eb.addr || per_wr !== eb.wr || per_rd !== eb.rd ||
              (eb.wr && per_dat_in !== eb.dat)) begin
            bad++;
            $display("FAIL bus_phase: got addr=%h wr=%b rd=%b dat=%h, expected addr=%h wr=%b rd=%b dat=%h",
                     per_addr, per_wr, per_rd, per_dat_in, eb.addr, eb.wr, eb.rd, eb.dat);
          end
        end
      end
      if (m0_ack && m1_ack) begin
        total++;
        bad++;
        $display("FAIL double_ack: got both acks high, expected at most one");
      end else if (m0_ack || m1_ack) begin
        total++;
        got_rd = m1_ack ? m1_rdata : m0_rdata;
        if (ack_q.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: got ack id=%0d, expected none", m1_ack);
        end else begin
          ea = ack_q.pop_front();
          if (m1_ack !== ea.id || got_rd !== ea.rdata || cyc != ea.cyc) begin
            bad++;
            $display("FAIL ack: got id=%0d rdata=%h cycle=%0d, expected id=%0d rdata=%h cycle=%0d",
                     m1_ack, got_rd, cyc, ea.id, ea.rdata, ea.cyc);
          end
        end
      end
    end
  end

  task automatic push_write(input logic id, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd_keep);
    bus_q.push_back('{4'h0, 1'b1, 1'b0, d});
    bus_q.push_back('{4'h4, 1'b1, 1'b0, a});
    bus_q.push_back('{4'h8, 1'b1, 1'b0, 8'h00});
    ack_q.push_back('{id, rd_keep, 4});
  endtask

  task automatic push_read(input logic id, input logic [7:0] a, input logic [7:0] d);
    bus_q.push_back('{4'h4, 1'b1, 1'b0, a});
    bus_q.push_back('{4'h8, 1'b0, 1'b1, 8'h00});
    bus_q.push_back('{4'h2, 1'b0, 1'b1, 8'h00});
    ack_q.push_back('{id, d, 5});
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (bus_q.size() == 0 && ack_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || per_cs !== 1'b0 || per_wr !== 1'b0 || per_rd !== 1'b0 ||
        per_addr !== 4'h0 || per_dat_in !== 8'h00 || m0_ack !== 1'b0 || m1_ack !== 1'b0 ||
        m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got busy=%b cs=%b wr=%b rd=%b addr=%h ack=%b%b rdata=%h/%h, expected all zero",
               busy, per_cs, per_wr, per_rd, per_addr, m0_ack, m1_ack, m0_rdata, m1_rdata);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_write;
    bit ok;
    repeat (2) @(negedge clk);
    push_write(1'b0, 8'h80, 8'h0B, 8'h00);
    m0_we = 1; m0_addr = 8'h80; m0_wdata = 8'h0B; m0_req = 1;
    @(posedge clk);
    #1 m0_req = 0; m0_addr = 8'hFF; m0_wdata = 8'hFF;
    drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_drain: got %0d bus/%0d ack pending, expected 0", bus_q.size(), ack_q.size()); end
  endtask

  task automatic test_read;
    bit ok;
    repeat (2) @(negedge clk);
    per_dat_out = 8'h55;
    push_read(1'b1, 8'h80, 8'h55);
    m1_we = 0; m1_addr = 8'h80; m1_req = 1;
    @(posedge clk);
    #1 m1_req = 0; m1_addr = 8'h00;
    drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL read_drain: got %0d bus/%0d ack pending, expected 0", bus_q.size(), ack_q.size()); end
    total++;
    if (m0_rdata !== 8'h00) begin bad++; $display("FAIL read_other_rdata: got %h, expected 00", m0_rdata); end
  endtask

  task automatic test_pulse;
    bit ok;
    bit quiet = 1'b1;
    repeat (2) @(negedge clk);
    per_dat_out = 8'h3C;
    push_read(1'b0, 8'h21, 8'h3C);
    m0_we = 0; m0_addr = 8'h21; m0_req = 1;
    @(posedge clk);
    #1 m0_req = 0;
    drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pulse_drain: got %0d bus/%0d ack pending, expected 0", bus_q.size(), ack_q.size()); end
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL pulse_regrant: got busy after single request, expected idle"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit found = 1'b0;
    bit quiet = 1'b1;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    m0_we = 1; m0_addr = 8'h12; m0_wdata = 8'h34; m0_req = 1;
    @(posedge clk);
    #1 m0_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (per_cs && per_addr == 4'h4) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL reset_mid_reach: got no W_ADDR phase, expected one"); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (per_cs !== 1'b0 || busy !== 1'b0 || m0_ack !== 1'b0 || m0_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_async: got cs=%b busy=%b ack=%b rdata=%h, expected 0 0 0 00", per_cs, busy, m0_ack, m0_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL reset_mid_abandon: got activity after reset, expected idle"); end
    mon_en = 1'b1;
    per_dat_out = 8'h9C;
    push_read(1'b1, 8'hC3, 8'h9C);
    m1_we = 0; m1_addr = 8'hC3; m1_req = 1;
    @(posedge clk);
    #1 m1_req = 0;
    drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_after: got %0d bus/%0d ack pending, expected 0", bus_q.size(), ack_q.size()); end
  endtask

  task automatic test_tie;
    bit ok;
    rst_n = 1'b0;
    per_dat_out = 8'h44;
    m0_we = 1; m0_addr = 8'h11; m0_wdata = 8'h22;
    m1_we = 0; m1_addr = 8'h33;
    m0_req = 1; m1_req = 1;
    push_write(1'b0, 8'h11, 8'h22, 8'h00);
    push_read(1'b1, 8'h33, 8'h44);
    push_write(1'b0, 8'h11, 8'h22, 8'h00);
    push_read(1'b1, 8'h33, 8'h44);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain(60, ok);
    m0_req = 0; m1_req = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL tie_drain: got %0d bus/%0d ack pending, expected 0", bus_q.size(), ack_q.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold3;
    logic [3:0] ea;
    logic [7:0] ed;
    logic       ecs, eack;
    repeat (2) @(negedge clk);
    h0_we = 1; h0_addr = 8'h5A; h0_wdata = 8'hA5; h0_req = 1;
    @(posedge clk);
    #1 h0_req = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ecs  = (c <= 9);
      ea   = (c <= 3) ? 4'h0 : (c <= 6) ? 4'h4 : (c <= 9) ? 4'h8 : 4'h0;
      ed   = (c <= 3) ? 8'hA5 : (c <= 6) ? 8'h5A : 8'h00;
      eack = (c == 10);
      total++;
      if (h_cs !== ecs || h_wr !== ecs || h_rd !== 1'b0 || h_addr !== ea ||
          h_dat_in !== ed || h0_ack !== eack || h1_ack !== 1'b0) begin
        bad++;
        $display("FAIL hold3_c%0d: got cs=%b wr=%b addr=%h dat=%h ack=%b, expected cs=%b wr=%b addr=%h dat=%h ack=%b",
                 c, h_cs, h_wr, h_addr, h_dat_in, h0_ack, ecs, ecs, ea, ed, eack);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_pulse;
    test_reset_mid;
    test_tie;
    test_hold3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
